// File: rtl/calc_seq_ctrl.sv
// Keypad-driven BCD calculator sequencer: debounced key events, operand entry FSM and
// a digit-serial BCD add/subtract engine. Define CALC_SUB_EN to enable the subtract key (0xB).
module calc_seq_ctrl #(
  parameter int RELEASE_CNT = 16,
  parameter int MAX_DIGITS  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      press,
  input  logic [3:0]                scan_code,
  output logic [2:0]                state,
  output logic [4*MAX_DIGITS-1:0]   op_a,
  output logic [4*MAX_DIGITS-1:0]   op_b,
  output logic [2:0]                digit_cnt,
  output logic [4*MAX_DIGITS+3:0]   result,
  output logic                      neg,
  output logic                      key_ack,
  output logic                      done
);

  localparam int OW  = 4 * MAX_DIGITS;
  localparam int RCW = $clog2(RELEASE_CNT + 1);
  localparam int CCW = $clog2(MAX_DIGITS + 1);
  localparam logic [RCW-1:0] REL_MAX = RCW'(RELEASE_CNT);
  localparam logic [2:0]     DMAX    = 3'(MAX_DIGITS);
  localparam logic [CCW-1:0] CLAST   = CCW'(MAX_DIGITS);

`ifdef CALC_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER_A = 3'd1,
    ENTER_B = 3'd2,
    CALC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t cur_st, nxt_st;

  logic [RCW-1:0] rel_cnt;
  logic           key_ev;
  logic           is_digit, is_op, is_eq, is_clr;

  logic           op_sub, op_sub_n;
  logic           swap, swap_n;
  logic [CCW-1:0] calc_cnt, calc_cnt_n;
  logic [OW-1:0]  wa, wa_n, wb, wb_n;
  logic [OW-5:0]  acc, acc_n;
  logic           cy, cy_n;
  logic [OW-1:0]  op_a_n, op_b_n;
  logic [2:0]     cnt_n;
  logic [OW+3:0]  res_n;
  logic           neg_n, ack_n, done_n;
  logic [4:0]     dig;

  // Single BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a, input logic [3:0] b,
                                                input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  // Single BCD digit subtract a - b - bin: returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_sub_digit(input logic [3:0] a, input logic [3:0] b,
                                                input logic bin);
    logic signed [5:0] d;
    d = $signed({2'b0, a}) - $signed({2'b0, b}) - $signed({5'b0, bin});
    if (d < 6'sd0) return {1'b1, 4'(d + 6'sd10)};
    else           return {1'b0, d[3:0]};
  endfunction

  // A new key needs RELEASE_CNT quiet cycles first; holding press keeps the counter cleared,
  // so a held or bouncing key yields a single event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rel_cnt <= REL_MAX;
    else if (press)              rel_cnt <= '0;
    else if (rel_cnt != REL_MAX) rel_cnt <= rel_cnt + 1'b1;
  end

  assign key_ev   = press && (rel_cnt == REL_MAX);
  assign is_digit = (scan_code <= 4'd9);
  assign is_op    = (scan_code == 4'hA) || (SUB_EN && (scan_code == 4'hB));
  assign is_eq    = (scan_code == 4'hE);
  assign is_clr   = (scan_code == 4'hF);

  assign dig = op_sub ? bcd_sub_digit(wa[3:0], wb[3:0], cy)
                      : bcd_add_digit(wa[3:0], wb[3:0], cy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= IDLE;
    else     cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st     = cur_st;
    op_a_n     = op_a;
    op_b_n     = op_b;
    cnt_n      = digit_cnt;
    op_sub_n   = op_sub;
    swap_n     = swap;
    calc_cnt_n = calc_cnt;
    wa_n       = wa;
    wb_n       = wb;
    acc_n      = acc;
    cy_n       = cy;
    res_n      = result;
    neg_n      = neg;
    ack_n      = 1'b0;
    done_n     = 1'b0;

    if (key_ev && is_clr && (cur_st != CALC)) begin
      nxt_st   = IDLE;
      op_a_n   = '0;
      op_b_n   = '0;
      cnt_n    = '0;
      op_sub_n = 1'b0;
      swap_n   = 1'b0;
      res_n    = '0;
      neg_n    = 1'b0;
      ack_n    = 1'b1;
    end else begin
      case (cur_st)
        IDLE: begin
          if (key_ev && is_digit) begin
            op_a_n = OW'(scan_code);
            cnt_n  = 3'd1;
            ack_n  = 1'b1;
            nxt_st = ENTER_A;
          end
        end
        ENTER_A: begin
          if (key_ev && is_digit && (digit_cnt < DMAX)) begin
            op_a_n = {op_a[OW-5:0], scan_code};
            cnt_n  = digit_cnt + 3'd1;
            ack_n  = 1'b1;
          end else if (key_ev && is_op) begin
            op_sub_n = (scan_code == 4'hB);
            cnt_n    = '0;
            ack_n    = 1'b1;
            nxt_st   = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_ev && is_digit && (digit_cnt < DMAX)) begin
            op_b_n = {op_b[OW-5:0], scan_code};
            cnt_n  = digit_cnt + 3'd1;
            ack_n  = 1'b1;
          end else if (key_ev && is_op) begin
            op_sub_n = (scan_code == 4'hB);
            ack_n    = 1'b1;
          end else if (key_ev && is_eq) begin
            calc_cnt_n = '0;
            ack_n      = 1'b1;
            nxt_st     = CALC;
          end
        end
        CALC: begin
          if (calc_cnt == '0) begin
            // Compare cycle: order operands so subtraction never goes below zero.
            swap_n     = op_sub && (op_b > op_a);
            wa_n       = swap_n ? op_b : op_a;
            wb_n       = swap_n ? op_a : op_b;
            acc_n      = '0;
            cy_n       = 1'b0;
            calc_cnt_n = calc_cnt + 1'b1;
          end else begin
            acc_n      = {dig[3:0], acc[OW-5:4]};
            wa_n       = wa >> 4;
            wb_n       = wb >> 4;
            cy_n       = dig[4];
            calc_cnt_n = calc_cnt + 1'b1;
            if (calc_cnt == CLAST) begin
              res_n  = {3'b0, dig[4] & ~op_sub, dig[3:0], acc};
              neg_n  = SUB_EN & swap;
              done_n = 1'b1;
              nxt_st = DONE;
            end
          end
        end
        DONE: begin
          if (key_ev && is_digit) begin
            op_a_n = OW'(scan_code);
            op_b_n = '0;
            res_n  = '0;
            neg_n  = 1'b0;
            cnt_n  = 3'd1;
            ack_n  = 1'b1;
            nxt_st = ENTER_A;
          end
        end
        default: nxt_st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      digit_cnt <= '0;
      op_sub    <= 1'b0;
      swap      <= 1'b0;
      calc_cnt  <= '0;
      wa        <= '0;
      wb        <= '0;
      acc       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      neg       <= 1'b0;
      key_ack   <= 1'b0;
      done      <= 1'b0;
    end else begin
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      digit_cnt <= cnt_n;
      op_sub    <= op_sub_n;
      swap      <= swap_n;
      calc_cnt  <= calc_cnt_n;
      wa        <= wa_n;
      wb        <= wb_n;
      acc       <= acc_n;
      cy        <= cy_n;
      result    <= res_n;
      neg       <= neg_n;
      key_ack   <= ack_n;
      done      <= done_n;
    end
  end

  assign state = cur_st;

endmodule
